// File: rtl/bp_update_scheduler.sv
// Round-robin merge of two branch-resolution update streams into one PHT write port through a DEPTH-entry FIFO.
// Issue latency 2 cycles (1 with BP_UPD_BYPASS_EN); ready is withheld when full or on flush, issue stalls on hold.
module bp_update_scheduler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_pc,
    input  logic             req0_taken,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_pc,
    input  logic             req1_taken,
    output logic             req1_ready,
    input  logic             hold,
    input  logic             flush,
    output logic             update_en,
    output logic [31:0]      update_pc,
    output logic             actual_taken,
    output logic [CNT_W-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_t;

    upd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, free, push_n, count_next;
    logic             prio;
    logic             xfer0, xfer1, pop, bypass;
    upd_t             first, second, w0;
    logic             first_vld, second_vld, w0_vld, w1_vld;

    assign free      = CNT_W'(DEPTH) - count;
    assign occupancy = count;

    // With one slot left the favoured unit wins; the other only gets it if the favoured one is idle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!flush) begin
            if (free >= CNT_W'(2)) begin
                req0_ready = 1'b1;
                req1_ready = 1'b1;
            end else if (free == CNT_W'(1)) begin
                if (prio) begin
                    req1_ready = 1'b1;
                    req0_ready = !req1_valid;
                end else begin
                    req0_ready = 1'b1;
                    req1_ready = !req0_valid;
                end
            end
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    always_comb begin
        first      = '{pc: req0_pc, taken: req0_taken};
        second     = '{pc: req1_pc, taken: req1_taken};
        first_vld  = xfer0 || xfer1;
        second_vld = xfer0 && xfer1;
        if (xfer0 && xfer1 && prio) begin
            first  = '{pc: req1_pc, taken: req1_taken};
            second = '{pc: req0_pc, taken: req0_taken};
        end else if (!xfer0) begin
            first  = '{pc: req1_pc, taken: req1_taken};
        end
    end

    assign pop = (count != '0) && !hold && !flush;

`ifdef BP_UPD_BYPASS_EN
    assign bypass = (count == '0) && !hold && !flush && first_vld;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed update takes the first-ordered slot, so any companion shifts down into w0.
    assign w0         = bypass ? second : first;
    assign w0_vld     = bypass ? second_vld : first_vld;
    assign w1_vld     = bypass ? 1'b0 : second_vld;
    assign push_n     = CNT_W'(w0_vld) + CNT_W'(w1_vld);
    assign count_next = count + push_n - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (w0_vld) mem[wr_ptr] <= w0;
        if (w1_vld) mem[wr_ptr + PTR_W'(1)] <= second;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            prio         <= 1'b0;
            update_en    <= 1'b0;
            update_pc    <= '0;
            actual_taken <= 1'b0;
        end else if (flush) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            update_en <= 1'b0;
        end else begin
            count     <= count_next;
            wr_ptr    <= wr_ptr + PTR_W'(push_n);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            update_en <= pop || bypass;
            if (pop) begin
                {update_pc, actual_taken} <= mem[rd_ptr];
            end else if (bypass) begin
                {update_pc, actual_taken} <= first;
            end
            if (req0_valid && req1_valid && (xfer0 || xfer1)) prio <= ~prio;
        end
    end
endmodule
